instr_mem_ldr: RTL and testbench

Loadable, parametrised instruction memory for the MIPS32 core: successor to the fixed-content instruction ROM. Adds a word-serial program load port, a registered (1-cycle) fetch port with ready/valid handshake, a program-length register so unloaded words read as NOP, and correct out-of-range detection. Sits between the boot/debug loader and the fetch stage of the datapath.

---
 rtl/mips_pkg.sv | 14 +
 rtl/instr_mem_ldr_if.sv | 35 +++
 rtl/instr_mem_ldr_imem_ram.sv | 31 +++
 rtl/instr_mem_ldr.sv | 118 +++++++++++
 tb/tb_instr_mem_ldr.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: instruction width, the NOP encoding and the
// loader state type used by the loadable instruction memory.
package mips_pkg;

    localparam int          MIPS_DATA_W = 32;
    localparam logic [31:0] MIPS_NOP    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_mem_ldr_if.sv
// Bus between the boot/debug loader + fetch stage (master) and the loadable
// instruction memory (slave): word-serial load port and registered fetch port.
interface instr_mem_ldr_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_busy;
    logic [ADDR_W:0]   prog_len;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req, fetch_addr,
        input  load_busy, prog_len,
        input  fetch_ready, fetch_valid, fetch_data, fetch_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req, fetch_addr,
        output load_busy, prog_len,
        output fetch_ready, fetch_valid, fetch_data, fetch_err
    );

endinterface

// File: rtl/instr_mem_ldr_imem_ram.sv
// DEPTH x DATA_W instruction storage: one synchronous write port and one
// synchronous, enabled read port (read-first). Contents are never reset.
module imem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_ldr.sv
// Loadable instruction memory: loader FSM with write pointer and program
// length, plus a 1-cycle fetch port that returns NOP for unloaded words.
module instr_mem_ldr
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = MIPS_DATA_W,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP)
) (
    input logic           clk,
    input logic           rst_n,
    instr_mem_ldr_if.slave bus
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              fetch_hit_q, fetch_hit_d;

    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic              fetch_ready;
    logic              fetch_acc;
    logic [ADDR_W:0]   fetch_addr_x;
    logic              addr_in_range;
    logic              addr_loaded;
    logic              rd_en;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            wr_ptr_q      <= '0;
            prog_len_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_hit_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            prog_len_q    <= prog_len_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            fetch_hit_q   <= fetch_hit_d;
        end
    end

    // load_start restarts from word 0 in every state, including a word written the same cycle
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        we         = 1'b0;
        wr_addr    = wr_ptr_q;

        if (bus.load_start) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            wr_addr  = '0;
        end

        if ((bus.load_start || state_q == ST_LOAD) && bus.load_valid) begin
            we = 1'b1;
            if (bus.load_last || wr_addr == LAST_PTR) begin
                state_d    = ST_RUN;
                prog_len_d = {1'b0, wr_addr} + (ADDR_W+1)'(1);
            end else begin
                wr_ptr_d = wr_addr + ADDR_W'(1);
            end
        end
    end

    // Range checks at ADDR_W+1 bits so DEPTH == 2^ADDR_W compares correctly
    always_comb begin
        fetch_ready   = (state_q != ST_LOAD);
        fetch_acc     = bus.fetch_req && fetch_ready;
        fetch_addr_x  = {1'b0, bus.fetch_addr};
        addr_in_range = (fetch_addr_x < DEPTH_X);
        addr_loaded   = (fetch_addr_x < prog_len_q);
        rd_en         = fetch_acc && addr_in_range && addr_loaded;

        fetch_valid_d = fetch_acc;
        fetch_err_d   = fetch_err_q;
        fetch_hit_d   = fetch_hit_q;
        if (fetch_acc) begin
            fetch_err_d = !addr_in_range;
            fetch_hit_d = rd_en;
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_addr),
        .wdata (bus.load_data),
        .re    (rd_en),
        .raddr (bus.fetch_addr),
        .rdata (ram_rdata)
    );

    assign bus.load_busy   = (state_q == ST_LOAD);
    assign bus.prog_len    = prog_len_q;
    assign bus.fetch_ready = fetch_ready;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.fetch_data  = fetch_hit_q ? ram_rdata : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_ldr.sv
// Bench for instr_mem_ldr (DEPTH=200 build): directed table of fetches,
// hand-written load/restart/reset sequences, then random traffic vs a model.
module tb_instr_mem_ldr;

    localparam int          ADDR_W = 8;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 200;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    localparam logic [31:0] PROG [13] = '{
        32'h0C01_0018, 32'h0401_00FA, 32'h2002_0005, 32'h2003_000C,
        32'h0043_2020, 32'hAC04_0010, 32'h8C05_0010, 32'h10A4_0002,
        32'h2006_0001, 32'h0800_0000, 32'h0000_0000, 32'h2007_0007,
        32'hFFFF_FFFF
    };

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instr_mem_ldr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_mem_ldr #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: memory contents, program length, loading flag, last fetch result
    logic [31:0] m_mem [256];
    int          m_len;
    int          m_ptr;
    bit          m_loading;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_len     = 0;
        m_ptr     = 0;
        m_valid   = 1'b0;
        m_data    = NOP;
        m_err     = 1'b0;
    endtask

    task automatic idle();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
    endtask

    task automatic check_model();
        chk("fetch_valid", bus.fetch_valid, m_valid);
        chk("fetch_data", bus.fetch_data, m_data);
        if (m_valid) chk("fetch_err", bus.fetch_err, m_err);
        chk("load_busy", bus.load_busy, m_loading);
        chk("fetch_ready", bus.fetch_ready, !m_loading);
        chk("prog_len", bus.prog_len, m_len);
    endtask

    // Predict from the inputs presented this cycle, clock, then compare
    task automatic tick();
        bit acc;
        int a;
        acc = bus.fetch_req && !m_loading;
        a   = int'(bus.fetch_addr);
        m_valid = acc;
        if (acc) begin
            m_err  = (a >= DEPTH);
            m_data = (a >= DEPTH || a >= m_len) ? NOP : m_mem[a];
        end
        if (bus.load_start) begin
            m_loading = 1'b1;
            m_ptr     = 0;
        end
        if (m_loading && bus.load_valid) begin
            m_mem[m_ptr] = bus.load_data;
            if (bus.load_last || m_ptr == DEPTH - 1) begin
                m_loading = 1'b0;
                m_len     = m_ptr + 1;
            end else begin
                m_ptr++;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic start_pulse();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        tick();
        bus.fetch_req  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [17];
        for (int i = 0; i < 13; i++) tbl[i] = '{addr: ADDR_W'(i), data: PROG[i], err: 1'b0};
        tbl[13] = '{addr: 8'd13,  data: NOP, err: 1'b0};
        tbl[14] = '{addr: 8'd199, data: NOP, err: 1'b0};
        tbl[15] = '{addr: 8'd250, data: NOP, err: 1'b1};
        tbl[16] = '{addr: 8'd255, data: NOP, err: 1'b1};

        idle();
        model_reset();
        #12;
        chk("rst_ready", bus.fetch_ready, 1);
        chk("rst_busy", bus.load_busy, 0);
        chk("rst_len", bus.prog_len, 0);
        chk("rst_valid", bus.fetch_valid, 0);
        chk("rst_data", bus.fetch_data, NOP);
        chk("rst_err", bus.fetch_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fetch(8'd0);
        chk("empty_fetch_valid", bus.fetch_valid, 1);
        chk("empty_fetch_data", bus.fetch_data, NOP);
        chk("empty_fetch_err", bus.fetch_err, 0);
        tick();
        chk("valid_drops", bus.fetch_valid, 0);

        // 13-word program, then the fetch table back-to-back
        start_pulse();
        chk("busy_after_start", bus.load_busy, 1);
        for (int i = 0; i < 13; i++) load_word(PROG[i], i == 12);
        chk("len13", bus.prog_len, 13);
        chk("busy_fell", bus.load_busy, 0);
        for (int i = 0; i < 17; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = tbl[i].addr;
            tick();
            chk($sformatf("tbl%0d_valid", i), bus.fetch_valid, 1);
            chk($sformatf("tbl%0d_data", i), bus.fetch_data, tbl[i].data);
            chk($sformatf("tbl%0d_err", i), bus.fetch_err, tbl[i].err);
        end
        bus.fetch_req = 1'b0;
        tick();

        // Fetch blocked during LOAD, restart after 5 words, 2 words + last
        start_pulse();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd1;
        for (int i = 0; i < 5; i++) begin
            load_word(32'hA000_0000 + 32'(i), 1'b0);
            chk("ready_low_in_load", bus.fetch_ready, 0);
            chk("no_valid_in_load", bus.fetch_valid, 0);
        end
        chk("len_kept_during_load", bus.prog_len, 13);
        start_pulse();
        load_word(32'hB000_0000, 1'b0);
        load_word(32'hB000_0001, 1'b0);
        load_word(32'hB000_0002, 1'b1);
        chk("restart_len3", bus.prog_len, 3);
        bus.fetch_addr = 8'd2;
        tick();
        chk("restart_w2", bus.fetch_data, 32'hB000_0002);
        bus.fetch_addr = 8'd3;
        tick();
        chk("restart_w3_nop", bus.fetch_data, NOP);
        bus.fetch_req = 1'b0;

        // Fetch + load_start + load_valid together: old word returned, new one next
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd0;
        bus.load_start = 1'b1;
        load_word(32'hC0DE_0000, 1'b0);
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        chk("same_cycle_old", bus.fetch_data, 32'hB000_0000);
        load_word(32'hC0DE_0001, 1'b1);
        chk("same_cycle_len2", bus.prog_len, 2);
        fetch(8'd1);
        chk("write_then_read", bus.fetch_data, 32'hC0DE_0001);
        fetch(8'd0);
        chk("start_word_at_0", bus.fetch_data, 32'hC0DE_0000);

        // Full-depth load with no load_last: auto-exit on the last word
        start_pulse();
        for (int i = 0; i < DEPTH; i++) load_word(32'h5000_0000 + 32'(i), 1'b0);
        chk("full_len", bus.prog_len, DEPTH);
        chk("full_busy_fell", bus.load_busy, 0);
        load_word(32'hDEAD_BEEF, 1'b0);
        fetch(8'(DEPTH - 1));
        chk("full_last_data", bus.fetch_data, 32'h5000_0000 + 32'(DEPTH - 1));
        chk("full_last_err", bus.fetch_err, 0);
        fetch(8'(DEPTH));
        chk("full_oob_err", bus.fetch_err, 1);
        chk("full_oob_data", bus.fetch_data, NOP);

        // Reset in the middle of a load
        start_pulse();
        for (int i = 0; i < 4; i++) load_word(32'h7000_0000 + 32'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", bus.load_busy, 0);
        chk("midrst_len", bus.prog_len, 0);
        chk("midrst_valid", bus.fetch_valid, 0);
        chk("midrst_ready", bus.fetch_ready, 1);
        chk("midrst_data", bus.fetch_data, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(8'd2);
        chk("midrst_fetch2", bus.fetch_data, NOP);
        chk("midrst_fetch2_valid", bus.fetch_valid, 1);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus.load_start = ($urandom_range(0, 49) == 0);
            bus.load_valid = ($urandom_range(0, 1) == 1);
            bus.load_data  = $urandom;
            bus.load_last  = ($urandom_range(0, 11) == 0);
            bus.fetch_req  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0) bus.fetch_addr = 8'($urandom_range(0, 40));
            else                           bus.fetch_addr = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
